// File: rtl/shift_reg_burst_if.sv
// Handshake/data bundle for shift_reg_burst; ROT exists only when SHREG_ROTATE_EN is defined.
interface shift_reg_burst_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic [1:0]       MODE;
  logic             SIN_R;
  logic             SIN_L;
  logic [WIDTH-1:0] D;
  logic             START;
  logic             DIR;
  logic [CNT_W-1:0] COUNT;
`ifdef SHREG_ROTATE_EN
  logic             ROT;
`endif
  logic [WIDTH-1:0] Q;
  logic             SOUT_R;
  logic             SOUT_L;
  logic             BUSY;
  logic             DONE;

  modport master (
    output MODE, SIN_R, SIN_L, D, START, DIR, COUNT,
`ifdef SHREG_ROTATE_EN
    output ROT,
`endif
    input  Q, SOUT_R, SOUT_L, BUSY, DONE
  );

  modport slave (
    input  MODE, SIN_R, SIN_L, D, START, DIR, COUNT,
`ifdef SHREG_ROTATE_EN
    input  ROT,
`endif
    output Q, SOUT_R, SOUT_L, BUSY, DONE
  );
endinterface

// File: rtl/shift_reg_burst.sv
// Universal shift register (hold/right/left/load) with a counted burst engine.
// Optional rotate feature enabled by defining SHREG_ROTATE_EN.
module shift_reg_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic              CLK,
  input logic              RST,
  shift_reg_burst_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] remain_q;
  logic             dir_q;
  logic             busy_q;
  logic             done_q;
  logic             man_rot;
  logic             burst_rot;

`ifdef SHREG_ROTATE_EN
  logic rot_q;
  assign man_rot   = bus.ROT;
  assign burst_rot = rot_q;
`else
  assign man_rot   = 1'b0;
  assign burst_rot = 1'b0;
`endif

  // With rot set, the bit leaving the word replaces the serial input.
  function automatic logic [WIDTH-1:0] shift_word(
    input logic [WIDTH-1:0] q,
    input logic             left,
    input logic             rot,
    input logic             sin_r,
    input logic             sin_l
  );
    if (left) return {q[WIDTH-2:0], (rot ? q[WIDTH-1] : sin_l)};
    else      return {(rot ? q[0] : sin_r), q[WIDTH-1:1]};
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      q_q      <= '0;
      remain_q <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SHREG_ROTATE_EN
      rot_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            if (bus.COUNT != '0) begin
              dir_q    <= bus.DIR;
              remain_q <= bus.COUNT;
              busy_q   <= 1'b1;
              state_q  <= SHIFT;
`ifdef SHREG_ROTATE_EN
              rot_q    <= bus.ROT;
`endif
            end else begin
              done_q <= 1'b1;
            end
          end else begin
            case (bus.MODE)
              2'b00: q_q <= q_q;
              2'b01: q_q <= shift_word(q_q, 1'b0, man_rot, bus.SIN_R, bus.SIN_L);
              2'b10: q_q <= shift_word(q_q, 1'b1, man_rot, bus.SIN_R, bus.SIN_L);
              2'b11: q_q <= bus.D;
            endcase
          end
        end
        SHIFT: begin
          q_q      <= shift_word(q_q, dir_q, burst_rot, bus.SIN_R, bus.SIN_L);
          remain_q <= remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.Q      = q_q;
  assign bus.SOUT_R = q_q[0];
  assign bus.SOUT_L = q_q[WIDTH-1];
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

endmodule

// File: tb/tb_shift_reg_burst.sv
// Scoreboard bench for shift_reg_burst: driver queues per-cycle expectations, monitor compares.
module tb_shift_reg_burst;

  logic CLK;
  logic RST;

  shift_reg_burst_if #(.WIDTH(8), .CNT_W(4)) bus();

  shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] q;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // Monitor: sample 3 time units after each rising edge, pop entries due this cycle.
  initial begin
    cyc = 0;
    forever begin
      @(posedge CLK);
      cyc++;
      #3;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || bus.Q !== e.q || bus.BUSY !== e.busy || bus.DONE !== e.done ||
            bus.SOUT_R !== e.q[0] || bus.SOUT_L !== e.q[7]) begin
          errors++;
          $display("FAIL %s: cyc=%0d Q=%h BUSY=%b DONE=%b SOUT_R=%b SOUT_L=%b, expected cyc=%0d Q=%h BUSY=%b DONE=%b",
                   e.name, cyc, bus.Q, bus.BUSY, bus.DONE, bus.SOUT_R, bus.SOUT_L,
                   e.cyc, e.q, e.busy, e.done);
        end
      end
    end
  end

  // Queue the expected state after the next edge, then advance past that edge.
  task automatic tick(input logic [7:0] q, input logic busy, input logic done, input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.q    = q;
    e.busy = busy;
    e.done = done;
    e.name = name;
    sb.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.MODE  = 2'b00;
    bus.START = 1'b0;
    bus.DIR   = 1'b0;
    bus.COUNT = 4'd0;
  endtask

  initial begin
    logic [7:0] e;
    checks = 0;
    errors = 0;
    RST       = 1'b0;
    bus.SIN_R = 1'b0;
    bus.SIN_L = 1'b0;
    bus.D     = 8'h00;
`ifdef SHREG_ROTATE_EN
    bus.ROT   = 1'b0;
`endif
    idle_inputs();

    // Reset behaviour
    tick(8'h00, 1'b0, 1'b0, "reset_initial");
    RST = 1'b1; bus.MODE = 2'b11; bus.D = 8'hA5;
    tick(8'hA5, 1'b0, 1'b0, "load_a5");
    RST = 1'b0;
    tick(8'h00, 1'b0, 1'b0, "reset_clears_a5");
    bus.D = 8'hFF;
    tick(8'h00, 1'b0, 1'b0, "reset_dominates_load_1");
    tick(8'h00, 1'b0, 1'b0, "reset_dominates_load_2");

    // Manual modes
    RST = 1'b1; bus.MODE = 2'b11; bus.D = 8'h96;
    tick(8'h96, 1'b0, 1'b0, "manual_load_96");
    bus.MODE = 2'b01; bus.SIN_R = 1'b1;
    tick(8'hCB, 1'b0, 1'b0, "manual_right_sin1");
    bus.MODE = 2'b10; bus.SIN_L = 1'b0;
    tick(8'h96, 1'b0, 1'b0, "manual_left_sin0");
    bus.MODE = 2'b00;
    for (int i = 0; i < 3; i++) tick(8'h96, 1'b0, 1'b0, "manual_hold");
    bus.MODE = 2'b01; bus.SIN_R = 1'b0;
    tick(8'h4B, 1'b0, 1'b0, "manual_right_sin0");
    bus.MODE = 2'b10; bus.SIN_L = 1'b1;
    tick(8'h97, 1'b0, 1'b0, "manual_left_sin1");

    // Burst right, with MODE/START noise during BUSY
    bus.MODE = 2'b11; bus.D = 8'h81;
    tick(8'h81, 1'b0, 1'b0, "load_81");
    bus.MODE = 2'b00; bus.START = 1'b1; bus.DIR = 1'b0; bus.COUNT = 4'd3; bus.SIN_R = 1'b0;
    tick(8'h81, 1'b1, 1'b0, "burst_r_accept");
    bus.MODE = 2'b11; bus.D = 8'hFF; bus.DIR = 1'b1; bus.COUNT = 4'd9;
    tick(8'h40, 1'b1, 1'b0, "burst_r_shift1");
    tick(8'h20, 1'b1, 1'b0, "burst_r_shift2");
    tick(8'h10, 1'b0, 1'b1, "burst_r_shift3_done");
    idle_inputs();
    tick(8'h10, 1'b0, 1'b0, "burst_r_after");

    // COUNT=0 burst
    bus.START = 1'b1; bus.COUNT = 4'd0; bus.MODE = 2'b11; bus.D = 8'hFF;
    tick(8'h10, 1'b0, 1'b1, "count0_done");
    idle_inputs();
    tick(8'h10, 1'b0, 1'b0, "count0_after");

    // Long left burst flushing ones
    bus.MODE = 2'b11; bus.D = 8'h00;
    tick(8'h00, 1'b0, 1'b0, "load_00");
    bus.MODE = 2'b00; bus.START = 1'b1; bus.DIR = 1'b1; bus.COUNT = 4'd15; bus.SIN_L = 1'b1;
    tick(8'h00, 1'b1, 1'b0, "burst_l15_accept");
    idle_inputs();
    e = 8'h00;
    for (int i = 1; i <= 15; i++) begin
      e = {e[6:0], 1'b1};
      tick(e, (i < 15), (i == 15), "burst_l15_step");
    end
    tick(8'hFF, 1'b0, 1'b0, "burst_l15_after");

    // Reset mid-burst, then a normal burst right after
    bus.START = 1'b1; bus.DIR = 1'b0; bus.COUNT = 4'd5; bus.SIN_R = 1'b0;
    tick(8'hFF, 1'b1, 1'b0, "midrst_accept");
    idle_inputs();
    tick(8'h7F, 1'b1, 1'b0, "midrst_shift1");
    RST = 1'b0;
    tick(8'h00, 1'b0, 1'b0, "midrst_abort");
    RST = 1'b1; bus.START = 1'b1; bus.DIR = 1'b1; bus.COUNT = 4'd2; bus.SIN_L = 1'b1;
    tick(8'h00, 1'b1, 1'b0, "post_rst_accept");
    idle_inputs();
    tick(8'h01, 1'b1, 1'b0, "post_rst_shift1");
    tick(8'h03, 1'b0, 1'b1, "post_rst_done");
    tick(8'h03, 1'b0, 1'b0, "post_rst_after");

`ifdef SHREG_ROTATE_EN
    bus.MODE = 2'b11; bus.D = 8'h81;
    tick(8'h81, 1'b0, 1'b0, "rot_load_81");
    bus.MODE = 2'b01; bus.ROT = 1'b1; bus.SIN_R = 1'b0;
    tick(8'hC0, 1'b0, 1'b0, "rot_manual_right");
    bus.MODE = 2'b00; bus.START = 1'b1; bus.DIR = 1'b1; bus.COUNT = 4'd8; bus.SIN_L = 1'b0;
    tick(8'hC0, 1'b1, 1'b0, "rot_burst_accept");
    idle_inputs();
    bus.ROT = 1'b0;
    e = 8'hC0;
    for (int i = 1; i <= 8; i++) begin
      e = {e[6:0], e[7]};
      tick(e, (i < 8), (i == 8), "rot_burst_step");
    end
    tick(8'hC0, 1'b0, 1'b0, "rot_burst_after");
`endif

    repeat (3) @(posedge CLK);
    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_burst.md
# shift_reg_burst

Parametrised universal shift register with an automatic burst engine. It holds, shifts right, shifts left or parallel-loads a WIDTH-bit word under MODE control. A START pulse runs a counted, self-timed shift sequence with BUSY/DONE handshaking. It is the general-purpose successor to the fixed 4-bit right-shift register and is used for serialisation and deserialisation in datapaths.

## Interface
- WIDTH, 8: register width in bits; minimum 2.
- CNT_W, 4: COUNT width; the required constraint is 2**CNT_W - 1 >= WIDTH.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- MODE  in  2  manual operation:
  - 00 = hold.
  - 01 = shift right.
  - 10 = shift left.
  - 11 = parallel load.
- SIN_R  in  1  serial input entering Q[WIDTH-1] on a right shift.
- SIN_L  in  1  serial input entering Q[0] on a left shift.
- D  in  WIDTH  parallel load data.
- START  in  1  burst request, sampled only in IDLE.
- DIR  in  1  burst direction, 0 = right, 1 = left; latched on accepted START.
- COUNT  in  CNT_W  number of burst shifts; latched on accepted START.
- Q  out  WIDTH  register contents.
- SOUT_R  out  1  equals Q[0].
- SOUT_L  out  1  equals Q[WIDTH-1].
- BUSY  out  1  high while a burst is in progress.
- DONE  out  1  single-cycle pulse at burst completion.

## Operation
- Reset (RST=0 at an edge) dominates all other inputs:
  - Q=0, BUSY=0, DONE=0, remaining count=0, FSM goes to IDLE.
- Right shift: Q <= {SIN_R, Q[WIDTH-1:1]}.
- Left shift: Q <= {Q[WIDTH-2:0], SIN_L}.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - START=1 and COUNT=k>0: latch DIR, set remaining=k, BUSY<=1, go to SHIFT. Q is unchanged on this edge and MODE is ignored.
  - START=1 and COUNT=0: no shift, DONE<=1 for one cycle, BUSY stays 0, remain in IDLE. Q is unchanged.
  - START=0: MODE executes manually each edge.
- SHIFT:
  - Each edge shifts once in the latched DIR, using the live SIN_R/SIN_L, and decrements remaining.
  - On the edge where remaining==1: the shift occurs, BUSY<=0, DONE<=1, go to IDLE.
  - MODE, D and START are ignored throughout SHIFT.
- DONE is otherwise 0. It never lasts more than one cycle.
- COUNT > WIDTH is legal. Extra shifts simply continue flushing serial input through the register.

## Timing
- Manual modes take effect with one-edge latency: Q updates on the edge that samples MODE.
- Burst timeline, with START sampled at edge 0 and COUNT=k:
  - Shifts occur at edges 1..k.
  - BUSY is high from after edge 0 until edge k.
  - DONE is high from edge k to edge k+1.
- A new START is accepted at edge k+1 at the earliest, giving back-to-back bursts with a one-cycle gap.
- SOUT_R and SOUT_L are combinational from Q and carry no extra latency.
- Reset mid-burst aborts immediately: Q=0, BUSY=0, no DONE pulse.

## Configuration
- Macro SHREG_ROTATE_EN.
- Defined:
  - Adds input port ROT (1 bit).
  - When ROT=1, the bit shifted out replaces the serial input. A right shift feeds Q[0] into MSB; a left shift feeds Q[WIDTH-1] into LSB.
  - ROT is live in manual modes and latched with DIR on an accepted START.
- Undefined: the ROT port is absent and shifts always use SIN_R/SIN_L.

## Test plan
All scenarios use WIDTH=8, CNT_W=4.
- Reset:
  - With Q=0xA5, drive RST=0 for one edge → Q=0x00, BUSY=0, DONE=0.
  - Hold RST=0 with MODE=11, D=0xFF → Q stays 0x00.
- Manual modes, applied in sequence:
  - MODE=11, D=0x96 → Q=0x96.
  - MODE=01, SIN_R=1 → Q=0xCB.
  - MODE=10, SIN_L=0 → Q=0x96.
  - MODE=00 for 3 edges → Q=0x96 throughout.
- Burst right:
  - Stimulus: Q=0x81, START with DIR=0, COUNT=3, SIN_R=0.
  - Q steps 0x40, 0x20, 0x10; BUSY is high exactly 3 cycles; DONE is high 1 cycle as BUSY falls.
  - MODE=11 and a second START during BUSY have no effect.
- Burst edge cases:
  - START with COUNT=0 → DONE pulses next cycle, BUSY never rises, Q unchanged.
  - Q=0x00, START with DIR=1, COUNT=15, SIN_L=1 → Q=0xFF after 8 shifts and remains 0xFF; BUSY high 15 cycles.
- Reset mid-burst:
  - START with COUNT=5; assert RST=0 at the 2nd shift edge → Q=0x00, BUSY=0, no DONE.
  - START on the following cycle is accepted normally.
- Rotate, with SHREG_ROTATE_EN defined:
  - Q=0x81, ROT=1, MODE=01 → Q=0xC0.
  - Then a burst with DIR=1, COUNT=8, ROT=1 → Q returns to 0xC0, and DONE pulses.
